cv32e40px_x_result_buf: RTL
===========================

// Module: cv32e40px_x_result_buf
//
// PURPOSE
// Result-side stage downstream of the x-interface dispatcher.
// Accepts coprocessor results (X result channel) into an in-order FIFO.
// Drains them into the integer register-file write port whenever the core WB stage is not using it.
// Pulses a scoreboard-clear to the dispatcher exactly when a result is committed to the RF.
// Replaces the hardwired x_result_ready=1 with real back-pressure.
//
// PARAMETERS
// DEPTH        2   FIFO entries; power of two, >=2
// STARVE_LIMIT 4   consecutive blocked cycles before WB stall is requested; >=1
//
// PORTS
// clk_i             in   1   clock
// rst_ni            in   1   asynchronous, active-low reset
// x_result_valid_i  in   1   coprocessor result valid
// x_result_ready_o  out  1   buffer can accept a result
// x_result_id_i     in   4   instruction id (stored, for debug/trace only)
// x_result_data_i   in   32  result data
// x_result_rd_i     in   5   destination register
// x_result_we_i     in   1   result writes rd
// core_wb_we_i      in   1   core WB stage owns the RF write port this cycle
// wb_stall_o        out  1   request core WB stage to hold one cycle (starvation relief)
// rf_we_o           out  1   RF write enable from this block
// rf_waddr_o        out  5   RF write address
// rf_wdata_o        out  32  RF write data
// sb_clr_valid_o    out  1   scoreboard-clear pulse
// sb_clr_rd_o       out  5   register whose scoreboard bit clears
// count_o           out  $clog2(DEPTH)+1  occupancy
//
// BEHAVIOUR
// - Reset: wr/rd pointers, count, starve counter = 0. All outputs 0 except x_result_ready_o = 1.
// - x_result_ready_o = (count < DEPTH). It must not depend on x_result_valid_i.
// - push = valid & ready.
//   - we=0: accepted and discarded; nothing is stored and there is no clear pulse.
//   - we=1: stores {id, rd, data} at wr_ptr.
// - pop = (count != 0) & ~core_wb_we_i. Core WB always has priority.
// - On pop:
//   - rf_we_o = (head.rd != 0).
//   - rf_waddr_o / rf_wdata_o = head fields.
//   - sb_clr_valid_o = 1 and sb_clr_rd_o = head.rd, including when rd = 0.
//   - The same-cycle pulse guarantees rf_we and the scoreboard clear coincide.
// - When not popping: rf_*, sb_clr_* = 0 (address/data driven 0, never X).
// - Latency: accepted in cycle N -> RF write no earlier than N+1 (without bypass).
// - Ordering: strictly FIFO. Duplicate rd entries write in arrival order.
// - Full: ready = 0, so there is no push-through when full. Push and pop in the same cycle
//   when not full: count unchanged, both pointers advance.
// - Pointers are PTR_W = $clog2(DEPTH) bits and wrap modulo DEPTH. count is PTR_W+1 bits.
// - Starvation:
//   - starve_cnt increments while (count != 0) & core_wb_we_i, saturating at STARVE_LIMIT.
//   - It resets to 0 on any pop or when count = 0.
//   - wb_stall_o = (starve_cnt == STARVE_LIMIT). The core deasserts core_wb_we_i next cycle,
//     allowing a pop, which clears the counter.
// - Reset mid-operation: contents dropped immediately. The dispatcher scoreboard resets in the
//   same domain, so no clears are owed.
// - Assertions (sim only):
//   - No push when count == DEPTH.
//   - No pop when count == 0.
//   - rf_we_o & core_wb_we_i never both 1.
//
// CONFIGURATION
// CV32E40PX_XRES_BYPASS_EN defined:
// - When count == 0, push with we=1, and ~core_wb_we_i: the result is written to the RF and
//   pulses sb_clr in the same cycle.
// - It is not stored, and count stays 0. Latency is 0.
// Undefined: every stored result spends at least one cycle in the FIFO. Latency is >= 1.
//
// TESTING
// - Reset release:
//   - Required: ready=1, count=0, rf_we=0, sb_clr_valid=0, wb_stall=0.
// - Single result: valid, rd=5, data=0xDEADBEEF, we=1, core_wb_we=0.
//   - Required: next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF, sb_clr rd=5. count 1->0.
//   - With BYPASS_EN the same outputs occur in the push cycle instead.
// - Fill: DEPTH pushes (rd=1,2) with core_wb_we=1.
//   - Required: ready=0 after the 2nd push. Third valid held, not accepted.
//   - Release core_wb_we: writes rd1 then rd2 in order; ready returns 1 the cycle count < 2.
// - Starvation: 1 entry, core_wb_we=1 for 10 cycles.
//   - Required: wb_stall=1 from the 5th blocked cycle.
//   - Once core_wb_we drops: pop occurs, wb_stall=0 next cycle.
// - Special cases: we=0 result is accepted with no rf_we and no sb_clr. we=1, rd=0 produces
//   sb_clr rd=0 with rf_we=0.
// - Reset asserted with 2 entries queued.
//   - Required: immediately count=0 and ready=1. No rf_we after release.

Source files
------------

// File: rtl/cv32e40px_x_result_buf.sv
// Result buffer between the coprocessor X result channel and the integer RF write port.
// Optional zero-latency bypass when empty: define CV32E40PX_XRES_BYPASS_EN.
module cv32e40px_x_result_buf #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic                       x_result_valid_i,
    output logic                       x_result_ready_o,
    input  logic [3:0]                 x_result_id_i,
    input  logic [31:0]                x_result_data_i,
    input  logic [4:0]                 x_result_rd_i,
    input  logic                       x_result_we_i,

    input  logic                       core_wb_we_i,
    output logic                       wb_stall_o,

    output logic                       rf_we_o,
    output logic [4:0]                 rf_waddr_o,
    output logic [31:0]                rf_wdata_o,

    output logic                       sb_clr_valid_o,
    output logic [4:0]                 sb_clr_rd_o,

    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
        $error("STARVE_LIMIT must be at least 1");
    end

    function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] val);
        return (val == STARVE_C) ? val : val + STV_W'(1);
    endfunction

    logic [3:0]       mem_id   [DEPTH];
    logic [4:0]       mem_rd   [DEPTH];
    logic [31:0]      mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [STV_W-1:0] starve_cnt_q;

    logic             push;
    logic             pop;
    logic             store;
    logic             bypass;
    logic             empty;

    logic [3:0]       head_id;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;

    assign empty            = (count_q == '0);
    assign x_result_ready_o = (count_q < DEPTH_C);
    assign push             = x_result_valid_i & x_result_ready_o;
    assign pop              = ~empty & ~core_wb_we_i;

`ifdef CV32E40PX_XRES_BYPASS_EN
    // An empty buffer with a free RF port lets the result go straight through.
    assign bypass = push & x_result_we_i & empty & ~core_wb_we_i;
`else
    assign bypass = 1'b0;
`endif

    // Results with we=0 are acknowledged but never occupy an entry.
    assign store = push & x_result_we_i & ~bypass;

    assign head_id   = mem_id[rd_ptr_q];
    assign head_rd   = mem_rd[rd_ptr_q];
    assign head_data = mem_data[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (store) begin
            mem_id[wr_ptr_q]   <= x_result_id_i;
            mem_rd[wr_ptr_q]   <= x_result_rd_i;
            mem_data[wr_ptr_q] <= x_result_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (store) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({store, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Counts consecutive cycles the head is held off the RF by core writeback.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else if (pop || empty) begin
            starve_cnt_q <= '0;
        end else if (core_wb_we_i) begin
            starve_cnt_q <= sat_inc(starve_cnt_q);
        end
    end

    assign wb_stall_o = (starve_cnt_q == STARVE_C);
    assign count_o    = count_q;

    // RF write and scoreboard clear are driven together so they can never drift apart.
    always_comb begin
        rf_we_o        = 1'b0;
        rf_waddr_o     = '0;
        rf_wdata_o     = '0;
        sb_clr_valid_o = 1'b0;
        sb_clr_rd_o    = '0;
        if (pop) begin
            rf_we_o        = (head_rd != '0);
            rf_waddr_o     = head_rd;
            rf_wdata_o     = head_data;
            sb_clr_valid_o = 1'b1;
            sb_clr_rd_o    = head_rd;
        end else if (bypass) begin
            rf_we_o        = (x_result_rd_i != '0);
            rf_waddr_o     = x_result_rd_i;
            rf_wdata_o     = x_result_data_i;
            sb_clr_valid_o = 1'b1;
            sb_clr_rd_o    = x_result_rd_i;
        end
    end

`ifndef SYNTHESIS
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (count_q == DEPTH_C)));
    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && empty));
    a_rf_port_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rf_we_o && core_wb_we_i));
    a_head_id_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> !$isunknown(head_id));
`endif

endmodule
